// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter that lets two producers share one FIFO write port.
// Optional statistics counters are enabled with `define WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int BURST = 4
) (
    input  logic             w_clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             full,
    output logic             ack0,
    output logic             ack1,
    output logic             grant0,
    output logic             grant1,
    output logic             fifo_w_en,
    output logic [WIDTH-1:0] fifo_data
`ifdef WR_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      acc0_cnt,
    output logic [15:0]      acc1_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] BCNT_MAX = CW'(BURST - 1);

    // One bit per owner, so the grant outputs come straight from state flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state, state_next;
    logic          last, last_next;
    logic [CW-1:0] bcnt, bcnt_next;
    logic          burst_done;

    assign burst_done = (bcnt == BCNT_MAX);

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            bcnt  <= bcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        bcnt_next  = bcnt;
        case (state)
            IDLE: begin
                bcnt_next = '0;
                if (req0 && req1)
                    state_next = last ? OWN0 : OWN1;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!req0 || (fifo_w_en && burst_done)) begin
                    last_next = 1'b0;
                    bcnt_next = '0;
                    if (req1)
                        state_next = OWN1;
                    else if (req0)
                        state_next = OWN0;
                    else
                        state_next = IDLE;
                end else if (fifo_w_en) begin
                    bcnt_next = bcnt + CW'(1);
                end
            end
            OWN1: begin
                if (!req1 || (fifo_w_en && burst_done)) begin
                    last_next = 1'b1;
                    bcnt_next = '0;
                    if (req0)
                        state_next = OWN0;
                    else if (req1)
                        state_next = OWN1;
                    else
                        state_next = IDLE;
                end else if (fifo_w_en) begin
                    bcnt_next = bcnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accept is combinational so a same-cycle rise of full suppresses it.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        fifo_data = data0;
        case (state)
            OWN0: ack0 = req0 & ~full;
            OWN1: begin
                ack1      = req1 & ~full;
                fifo_data = data1;
            end
            default: ;
        endcase
        fifo_w_en = ack0 | ack1;
    end

    assign grant0 = state[0];
    assign grant1 = state[1];

`ifdef WR_ARB_STATS_EN
    logic stall;

    assign stall = full & (((state == OWN0) & req0) | ((state == OWN1) & req1));

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0_cnt  <= '0;
            acc1_cnt  <= '0;
            stall_cnt <= '0;
        end else if (stats_clr) begin
            acc0_cnt  <= '0;
            acc1_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (ack0)
                acc0_cnt <= acc0_cnt + 16'd1;
            if (ack1)
                acc1_cnt <= acc1_cnt + 16'd1;
            if (stall)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven self-checking bench for fifo_wr_arbiter (BURST=4).
// Statistics checks run only when WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    logic        w_clk;
    logic        rst_n;
    logic        req0, req1, full;
    logic [15:0] data0, data1;
    logic        ack0, ack1, grant0, grant1, fifo_w_en;
    logic [15:0] fifo_data;
`ifdef WR_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] acc0_cnt, acc1_cnt, stall_cnt;
`endif

    int passCount = 0;
    int checkCount = 0;

    fifo_wr_arbiter #(.WIDTH(16), .BURST(4)) dut (
        .w_clk     (w_clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .full      (full),
        .ack0      (ack0),
        .ack1      (ack1),
        .grant0    (grant0),
        .grant1    (grant1),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data)
`ifdef WR_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .acc0_cnt  (acc0_cnt),
        .acc1_cnt  (acc1_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // ctl packs the expected {grant0, grant1, ack0, ack1, fifo_w_en}.
    typedef struct {
        logic        r0;
        logic        r1;
        logic        f;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [4:0]  ctl;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic r0, input logic r1, input logic f,
                                   input logic [15:0] d0, input logic [15:0] d1,
                                   input logic [4:0] ctl, input logic [15:0] data);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.f = f; v.d0 = d0; v.d1 = d1; v.ctl = ctl; v.data = data;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input vec_t v);
        req0  = v.r0;
        req1  = v.r1;
        full  = v.f;
        data0 = v.d0;
        data1 = v.d1;
    endtask

    function automatic logic [31:0] outVec();
        return {11'd0, grant0, grant1, ack0, ack1, fifo_w_en, fifo_data};
    endfunction

    // Each row: drive just after the rising edge, compare mid-cycle.
    task automatic runVectors(input string tag);
        foreach (vecs[i]) begin
            @(posedge w_clk);
            #1;
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("%s[%0d]", tag, i), outVec(), {11'd0, vecs[i].ctl, vecs[i].data});
        end
        vecs.delete();
    endtask

    task automatic doReset();
        @(posedge w_clk);
        #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        data0 = 16'h0;
        data1 = 16'h0;
        #2;
        checkOutput("reset_outputs", outVec(), 32'h0);
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; full = 1'b0;
        data0 = 16'h0; data1 = 16'h0;
`ifdef WR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Single producer, 6 words: burst wraps and ownership stays with 0.
        doReset();
        addVec(1, 0, 0, 16'h1001, 16'h0, 5'b00000, 16'h1001);
        addVec(1, 0, 0, 16'h1001, 16'h0, 5'b10101, 16'h1001);
        addVec(1, 0, 0, 16'h1002, 16'h0, 5'b10101, 16'h1002);
        addVec(1, 0, 0, 16'h1003, 16'h0, 5'b10101, 16'h1003);
        addVec(1, 0, 0, 16'h1004, 16'h0, 5'b10101, 16'h1004);
        addVec(1, 0, 0, 16'h1005, 16'h0, 5'b10101, 16'h1005);
        addVec(1, 0, 0, 16'h1006, 16'h0, 5'b10101, 16'h1006);
        addVec(0, 0, 0, 16'h0000, 16'h0, 5'b10000, 16'h0000);
        addVec(0, 0, 0, 16'h0000, 16'h0, 5'b00000, 16'h0000);
        runVectors("solo0");

        // Both producers continuously: tenures 0,1,0,1 of 4 words, no bubbles.
        doReset();
        addVec(1, 1, 0, 16'hA000, 16'hB000, 5'b00000, 16'hA000);
        addVec(1, 1, 0, 16'hA000, 16'hB000, 5'b10101, 16'hA000);
        addVec(1, 1, 0, 16'hA001, 16'hB000, 5'b10101, 16'hA001);
        addVec(1, 1, 0, 16'hA002, 16'hB000, 5'b10101, 16'hA002);
        addVec(1, 1, 0, 16'hA003, 16'hB000, 5'b10101, 16'hA003);
        addVec(1, 1, 0, 16'hA004, 16'hB000, 5'b01011, 16'hB000);
        addVec(1, 1, 0, 16'hA004, 16'hB001, 5'b01011, 16'hB001);
        addVec(1, 1, 0, 16'hA004, 16'hB002, 5'b01011, 16'hB002);
        addVec(1, 1, 0, 16'hA004, 16'hB003, 5'b01011, 16'hB003);
        addVec(1, 1, 0, 16'hA004, 16'hB004, 5'b10101, 16'hA004);
        addVec(1, 1, 0, 16'hA005, 16'hB004, 5'b10101, 16'hA005);
        addVec(1, 1, 0, 16'hA006, 16'hB004, 5'b10101, 16'hA006);
        addVec(1, 1, 0, 16'hA007, 16'hB004, 5'b10101, 16'hA007);
        addVec(1, 1, 0, 16'hA008, 16'hB004, 5'b01011, 16'hB004);
        addVec(1, 1, 0, 16'hA008, 16'hB005, 5'b01011, 16'hB005);
        addVec(1, 1, 0, 16'hA008, 16'hB006, 5'b01011, 16'hB006);
        addVec(1, 1, 0, 16'hA008, 16'hB007, 5'b01011, 16'hB007);
        addVec(0, 0, 0, 16'h0000, 16'h0000, 5'b10000, 16'h0000);
        addVec(0, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0000);
        runVectors("rr");

        // Full stall mid-tenure, handoff, early drop to IDLE, then a tie.
        doReset();
        addVec(1, 0, 0, 16'hC000, 16'hD000, 5'b00000, 16'hC000);
        addVec(1, 0, 0, 16'hC000, 16'hD000, 5'b10101, 16'hC000);
        addVec(1, 1, 0, 16'hC001, 16'hD000, 5'b10101, 16'hC001);
        addVec(1, 1, 1, 16'hC002, 16'hD000, 5'b10000, 16'hC002);
        addVec(1, 1, 1, 16'hC002, 16'hD000, 5'b10000, 16'hC002);
        addVec(1, 1, 1, 16'hC002, 16'hD000, 5'b10000, 16'hC002);
        addVec(1, 1, 0, 16'hC002, 16'hD000, 5'b10101, 16'hC002);
        addVec(1, 1, 0, 16'hC003, 16'hD000, 5'b10101, 16'hC003);
        addVec(0, 1, 0, 16'h0000, 16'hD000, 5'b01011, 16'hD000);
        addVec(0, 0, 0, 16'h0000, 16'hD001, 5'b01000, 16'hD001);
        addVec(1, 1, 0, 16'hE000, 16'hD001, 5'b00000, 16'hE000);
        addVec(1, 1, 0, 16'hE000, 16'hD001, 5'b10101, 16'hE000);
        addVec(0, 1, 0, 16'h0000, 16'hD001, 5'b10000, 16'h0000);
        addVec(0, 1, 0, 16'h0000, 16'hD001, 5'b01011, 16'hD001);
        runVectors("stall");

        // Asynchronous reset while OWN1 is accepting.
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctl", {27'd0, grant0, grant1, ack0, ack1, fifo_w_en}, 32'h0);
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 16'hF000;
        data1 = 16'hF100;
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_idle", outVec(), {11'd0, 5'b00000, 16'hF000});
        @(posedge w_clk);
        #1;
        checkOutput("post_reset_tie", outVec(), {11'd0, 5'b10101, 16'hF000});

`ifdef WR_ARB_STATS_EN
        doReset();
        addVec(1, 0, 0, 16'h0001, 16'h0000, 5'b00000, 16'h0001);
        addVec(1, 0, 0, 16'h0001, 16'h0000, 5'b10101, 16'h0001);
        addVec(1, 0, 0, 16'h0002, 16'h0000, 5'b10101, 16'h0002);
        addVec(1, 0, 0, 16'h0003, 16'h0000, 5'b10101, 16'h0003);
        addVec(1, 0, 0, 16'h0004, 16'h0000, 5'b10101, 16'h0004);
        addVec(1, 0, 1, 16'h0005, 16'h0000, 5'b10000, 16'h0005);
        addVec(1, 0, 1, 16'h0005, 16'h0000, 5'b10000, 16'h0005);
        addVec(1, 0, 0, 16'h0005, 16'h0000, 5'b10101, 16'h0005);
        addVec(0, 1, 0, 16'h0000, 16'h0021, 5'b10000, 16'h0000);
        addVec(0, 1, 0, 16'h0000, 16'h0021, 5'b01011, 16'h0021);
        addVec(0, 1, 0, 16'h0000, 16'h0022, 5'b01011, 16'h0022);
        addVec(0, 1, 0, 16'h0000, 16'h0023, 5'b01011, 16'h0023);
        addVec(0, 0, 0, 16'h0000, 16'h0000, 5'b01000, 16'h0000);
        runVectors("stats");
        checkOutput("acc0_cnt", {16'd0, acc0_cnt}, 32'd5);
        checkOutput("acc1_cnt", {16'd0, acc1_cnt}, 32'd3);
        checkOutput("stall_cnt", {16'd0, stall_cnt}, 32'd2);
        @(posedge w_clk);
        #1;
        stats_clr = 1'b1;
        @(posedge w_clk);
        #1;
        stats_clr = 1'b0;
        checkOutput("stats_clr", {acc0_cnt, acc1_cnt | stall_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
